// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_t      : fetch FSM encoding (IDLE, FETCH, TRAP)
//   NOP_INSTR          : ADDI x0,x0,0, shown on instr_o when nothing valid
//   RESET_ADDR_DEFAULT : default first fetch address after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_adder32.sv
// 32-bit unsigned adder, result modulo 2^32 (carry out discarded).
//   a   : operand A
//   b   : operand B
//   sum : a + b, low 32 bits
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: holds the fetch PC, issues instruction-memory
// requests and registers each returned word with its PC for decode.
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   stall_i              : freeze fetch (hold everything, no request)
//   redirect_i/_addr_i   : load a new PC; misaligned target traps
//   imem_ready_i/rdata_i : memory returns a word for imem_addr_o this cycle
//   imem_req_o/addr_o    : fetch request and address (fetch PC)
//   instr_o, pc_o        : registered instruction and its PC
//   pc_plus4_o           : pc_o + 4 (combinational)
//   instr_valid_o        : instr_o/pc_o hold a real instruction
//   misaligned_o         : set while trapped on a misaligned redirect
//   state_o              : current FSM state (fetch_state_t encoding)
//
// Handshake: a word is accepted when imem_req_o & imem_ready_i in the same
// cycle; the data must be valid that cycle and is registered on the edge.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = fetch_pkg::RESET_ADDR_DEFAULT,
  parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o,
  output logic        misaligned_o,
  output logic [1:0]  state_o
);

  import fetch_pkg::*;

  fetch_state_t state_q, state_n;
  logic [31:0]  fetch_pc_q, fetch_pc_n;
  logic [31:0]  instr_q, instr_n;
  logic [31:0]  pc_q, pc_n;
  logic         valid_q, valid_n;
  logic         mis_q, mis_n;
  logic [31:0]  seq_pc;
  logic         aligned;
  logic         accept;

  adder32 u_seq_add (
    .a   (fetch_pc_q),
    .b   (32'd4),
    .sum (seq_pc)
  );

  adder32 u_plus4_add (
    .a   (pc_q),
    .b   (32'd4),
    .sum (pc_plus4_o)
  );

  assign aligned    = (redirect_addr_i[1:0] == 2'b00);
  // A redirect suppresses the request, so a word returned alongside it is dropped.
  assign imem_req_o = (state_q == FETCH) & ~stall_i & ~redirect_i;
  assign accept     = imem_req_o & imem_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_ADDR;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      instr_q    <= instr_n;
      pc_q       <= pc_n;
      valid_q    <= valid_n;
      mis_q      <= mis_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    instr_n    = instr_q;
    pc_n       = pc_q;
    valid_n    = valid_q;
    mis_n      = mis_q;
    case (state_q)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (redirect_i) begin
          valid_n = 1'b0;
          if (aligned) begin
            fetch_pc_n = redirect_addr_i;
            instr_n    = NOP_INSTR;
          end else begin
            state_n = TRAP;
            mis_n   = 1'b1;
          end
        end else if (stall_i) begin
          // hold everything
        end else if (accept) begin
          instr_n    = imem_rdata_i;
          pc_n       = fetch_pc_q;
          valid_n    = 1'b1;
          fetch_pc_n = seq_pc;
        end else begin
          valid_n = 1'b0;
        end
      end
      TRAP: begin
        // Only an aligned redirect leaves the trap.
        if (redirect_i && aligned) begin
          state_n    = FETCH;
          mis_n      = 1'b0;
          fetch_pc_n = redirect_addr_i;
          instr_n    = NOP_INSTR;
          valid_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imem_addr_o   = fetch_pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign misaligned_o  = mis_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i;
  logic        rst_n_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        misaligned_o;
  logic [1:0]  state_o;

  int checks;
  int failures;

  pc_fetch_unit dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .instr_valid_o   (instr_valid_o),
    .misaligned_o    (misaligned_o),
    .state_o         (state_o)
  );

  // clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        ready;
    logic [31:0] rdata;
    logic        exp_req;   // before the edge
    logic [31:0] exp_addr;  // before the edge
    logic [31:0] exp_instr; // after the edge
    logic [31:0] exp_pc;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic        exp_mis;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] ra, logic ry,
                              logic [31:0] dat, logic req, logic [31:0] addr,
                              logic [31:0] ins, logic [31:0] pc, logic [31:0] pc4,
                              logic vl, logic ms, logic [1:0] s);
    vec_t v;
    v.stall = st; v.redir = rd; v.raddr = ra; v.ready = ry; v.rdata = dat;
    v.exp_req = req; v.exp_addr = addr; v.exp_instr = ins; v.exp_pc = pc;
    v.exp_pc4 = pc4; v.exp_valid = vl; v.exp_mis = ms; v.exp_state = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] ra,
                       input logic ry, input logic [31:0] dat);
    stall_i = st; redirect_i = rd; redirect_addr_i = ra;
    imem_ready_i = ry; imem_rdata_i = dat;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'd0, imem_req_o},    32'd0);
    check({tag, "_addr"},  imem_addr_o,            32'h0);
    check({tag, "_instr"}, instr_o,                NOP);
    check({tag, "_pc"},    pc_o,                   32'h0);
    check({tag, "_pc4"},   pc_plus4_o,             32'h4);
    check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    check({tag, "_mis"},   {31'd0, misaligned_o},  32'd0);
    check({tag, "_state"}, {30'd0, state_o},       {30'd0, IDLE});
  endtask

  task automatic apply(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    drive(v.stall, v.redir, v.raddr, v.ready, v.rdata);
    #1;
    check({t, "_req"},  {31'd0, imem_req_o}, {31'd0, v.exp_req});
    check({t, "_addr"}, imem_addr_o,         v.exp_addr);
    @(posedge clk_i);
    #1;
    check({t, "_instr"}, instr_o,                v.exp_instr);
    check({t, "_pc"},    pc_o,                   v.exp_pc);
    check({t, "_pc4"},   pc_plus4_o,             v.exp_pc4);
    check({t, "_valid"}, {31'd0, instr_valid_o}, {31'd0, v.exp_valid});
    check({t, "_mis"},   {31'd0, misaligned_o},  {31'd0, v.exp_mis});
    check({t, "_state"}, {30'd0, state_o},       {30'd0, v.exp_state});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //           st rd raddr         ry rdata         req addr          instr         pc            pc4           v  m  state
    // reset release and streaming from 0
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h0,        NOP,          32'h0,        32'h4,        0, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00A0_0093, 1, 32'h0,        32'h00A0_0093, 32'h0,       32'h4,        1, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00B0_0113, 1, 32'h4,        32'h00B0_0113, 32'h4,       32'h8,        1, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00C0_0193, 1, 32'h8,        32'h00C0_0193, 32'h8,       32'hC,        1, 0, FETCH));
    // stall three cycles: everything frozen at fetch 0xC
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h1111_1111, 0, 32'hC,        32'h00C0_0193, 32'h8,       32'hC,        1, 0, FETCH));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h1111_1111, 0, 32'hC,        32'h00C0_0193, 32'h8,       32'hC,        1, 0, FETCH));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h1111_1111, 0, 32'hC,        32'h00C0_0193, 32'h8,       32'hC,        1, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00D0_0213, 1, 32'hC,        32'h00D0_0213, 32'hC,       32'h10,       1, 0, FETCH));
    // memory not ready: bubble
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h5555_5555, 1, 32'h10,       32'h00D0_0213, 32'hC,       32'h10,       0, 0, FETCH));
    // redirect with stall and ready: word dropped
    vecs.push_back(mk(1, 1, 32'h100,      1, 32'h2222_2222, 0, 32'h10,       NOP,          32'hC,        32'h10,       0, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00E0_0293, 1, 32'h100,      32'h00E0_0293, 32'h100,     32'h104,      1, 0, FETCH));
    // misaligned redirect -> trap, held
    vecs.push_back(mk(0, 1, 32'h102,      1, 32'h3333_3333, 0, 32'h104,      32'h00E0_0293, 32'h100,     32'h104,      0, 1, TRAP));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h3333_3333, 0, 32'h104,      32'h00E0_0293, 32'h100,     32'h104,      0, 1, TRAP));
    vecs.push_back(mk(0, 1, 32'h201,      1, 32'h3333_3333, 0, 32'h104,      32'h00E0_0293, 32'h100,     32'h104,      0, 1, TRAP));
    // aligned redirect leaves the trap
    vecs.push_back(mk(0, 1, 32'h200,      1, 32'h4444_4444, 0, 32'h104,      NOP,          32'h100,      32'h104,      0, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00F0_0313, 1, 32'h200,      32'h00F0_0313, 32'h200,     32'h204,      1, 0, FETCH));
    // wrap at top of address space
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 32'h204,      NOP,          32'h200,      32'h204,      0, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0100_0393, 1, 32'hFFFF_FFFC, 32'h0100_0393, 32'hFFFF_FFFC, 32'h0,    1, 0, FETCH));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h0110_0413, 1, 32'h0,        32'h0110_0413, 32'h0,       32'h4,        1, 0, FETCH));

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_values("rst");
    rst_n_i = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // asynchronous reset mid-stream, between edges
    drive(0, 0, 32'h0, 1, 32'h0120_0493);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_values("arst");
    @(posedge clk_i);
    #1;
    check_reset_values("arst_hold");
    rst_n_i = 1'b1;
    // first edge goes to FETCH without a request
    #1;
    check("arst_idle_req", {31'd0, imem_req_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("arst_fetch_state", {30'd0, state_o}, {30'd0, FETCH});
    check("arst_first_req",   {31'd0, imem_req_o}, 32'd1);
    check("arst_first_addr",  imem_addr_o, 32'h0);
    @(posedge clk_i);
    #1;
    check("arst_first_instr", instr_o, 32'h0120_0493);
    check("arst_first_pc",    pc_o, 32'h0);
    check("arst_first_valid", {31'd0, instr_valid_o}, 32'd1);
    check("arst_next_addr",   imem_addr_o, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end of the RISC-V core.
- Holds the program counter and drives instruction-memory requests.
- Registers the fetched instruction and its PC for decode.
- pc_o and pc_plus4_o feed the downstream 32-bit adders (branch target, return address) and the next-PC logic.
- Handles stall, redirect (branch/jump) and misaligned-target trapping.

Parameters:
- RESET_ADDR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, ADDI x0,x0,0; value of instr_o when no valid instruction.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- stall_i  input  1  hazard stall from decode; freezes fetch.
- redirect_i  input  1  branch/jump taken; load new PC.
- redirect_addr_i  input  32  target PC for redirect.
- imem_ready_i  input  1  memory returns data for imem_addr_o this cycle.
- imem_rdata_i  input  32  instruction word, valid when imem_ready_i=1.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address (current PC register).
- instr_o  output  32  registered instruction to decode.
- pc_o  output  32  registered PC of instr_o.
- pc_plus4_o  output  32  pc_o + 4, combinational.
- instr_valid_o  output  1  instr_o/pc_o hold a real instruction.
- misaligned_o  output  1  redirect target had bits [1:0] != 0.

Behaviour:
- Interface: one clock, clk_i; reset rst_n_i is asynchronous and active-low.
- Reset is asynchronous: it takes effect immediately, including mid-fetch, and any in-flight word is dropped.
- Reset values:
  - fetch_pc = RESET_ADDR, so imem_addr_o = RESET_ADDR.
  - imem_req_o=0, instr_valid_o=0, misaligned_o=0.
  - instr_o=NOP_INSTR, pc_o=RESET_ADDR, state=IDLE.
- FSM states: IDLE, FETCH, TRAP.
  - IDLE -> FETCH unconditionally on the first edge after reset deasserts. No request is issued in IDLE.
  - FETCH: imem_req_o = ~stall_i & ~redirect_i.
  - FETCH -> TRAP: redirect_i=1 with redirect_addr_i[1:0] != 0.
  - TRAP: imem_req_o=0, instr_valid_o=0, misaligned_o=1, fetch_pc held.
  - TRAP -> FETCH: only on redirect_i=1 with an aligned address; misaligned_o clears on the same edge and fetch_pc loads that address. Otherwise TRAP is held until reset.
- Memory timing: the memory is zero-wait-capable. Data is valid in the same cycle imem_ready_i=1.
- Accept: imem_req_o & imem_ready_i. On the next edge:
  - instr_o <= imem_rdata_i, pc_o <= fetch_pc, instr_valid_o <= 1, fetch_pc <= fetch_pc + 4.
  - Latency is 1 cycle from accept to instr_valid_o.
  - Throughput is 1 instruction/cycle while ready stays high.
- FETCH with imem_ready_i=0 and no stall/redirect: instr_valid_o <= 0 (bubble); fetch_pc, instr_o, pc_o hold.
- Stall (stall_i=1, redirect_i=0): instr_o, pc_o, instr_valid_o and fetch_pc all hold; no request is issued.
- Redirect priority: redirect_i=1 (aligned) outranks stall_i and imem_ready_i.
  - fetch_pc <= redirect_addr_i; instr_valid_o <= 0; instr_o <= NOP_INSTR.
  - No request is issued that cycle, so any simultaneously returned word is discarded.
  - The first word from the target is valid 2 cycles after the redirect edge, given ready.
- Misaligned redirect: takes the FETCH -> TRAP transition above; instr_valid_o <= 0 and fetch_pc is unchanged.
- Arithmetic: all PC math is unsigned modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag.
- pc_plus4_o is always pc_o + 4, including while instr_valid_o=0.

Decomposition:
- fetch_pkg contains:
  - typedef enum logic [1:0] {IDLE, FETCH, TRAP} fetch_state_t.
  - localparam NOP_INSTR and localparam RESET_ADDR_DEFAULT.
- Sub-modules:
  - Instantiate the existing 32-bit adder twice: fetch_pc + 4 (next sequential PC) and pc_o + 4 (pc_plus4_o).
  - No further sub-modules; the FSM and registers are flat.

Test Plan:
1. Reset release, imem_ready_i=1, rdata 0x00A00093, 0x00B00113 -> imem_addr_o 0x0, then 0x4; instr_o=0x00A00093, pc_o=0x0, valid=1, one cycle after the first accept; pc_plus4_o=0x4.
2. Stream at 0x8, stall_i high 3 cycles -> imem_req_o=0, instr_o/pc_o frozen, imem_addr_o frozen at 0xC; resumes at 0xC when stall drops.
3. redirect_i=1, addr 0x100, together with stall_i=1 and imem_ready_i=1 -> returned word dropped, valid=0 next cycle, next imem_addr_o=0x100, pc_o=0x100 valid 2 cycles later.
4. redirect to 0x102 -> misaligned_o=1, imem_req_o=0 held; later redirect to 0x200 -> misaligned_o=0, fetch at 0x200.
5. Fetch at 0xFFFF_FFFC with ready -> next imem_addr_o=0x0000_0000; pc_plus4_o for that instruction = 0x0.
6. rst_n_i low mid-stream (between edges) -> outputs reach reset values immediately; after release, first fetch at RESET_ADDR.
